// File: rtl/keypad_scanner_if.sv
//------------------------------------------------------------------------------
// Module : keypad_scanner_if
// Brief  : Keypad matrix pins plus decoded key outputs of the keypad scanner.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_held,
        output multi_key
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_held,
        input  multi_key
    );
endinterface

`default_nettype wire

// File: rtl/keypad_scanner.sv
//------------------------------------------------------------------------------
// Module : keypad_scanner
// Brief  : 4x4 matrix keypad column scanner with debounce and hex key decode.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module keypad_scanner #(
    parameter int SCAN_DIV_BITS  = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clk,
    input  logic              clr,
    keypad_scanner_if.master  kp
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRS_DEB = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_REL_DEB = 2'd3;

    localparam logic [3:0]               c_deb        = 4'(DEBOUNCE_SCANS);
    localparam logic [SCAN_DIV_BITS-1:0] c_dwell_last = '1;

    function automatic logic [3:0] key_map(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]               r_row_meta;
    logic [3:0]               r_row_sync;
    logic [SCAN_DIV_BITS-1:0] r_dwell_cnt;
    logic [1:0]               r_col_idx;
    logic [15:0]              r_snapshot;
    logic                     r_scan_end;

    logic [1:0]  r_state;
    logic [3:0]  r_cand;
    logic [3:0]  r_cnt;
    logic [3:0]  r_key_code;
    logic        r_key_valid;
    logic        r_key_held;
    logic        r_multi_key;

    logic        w_sample;
    logic        w_any;
    logic        w_multi;
    logic        w_single;
    logic [3:0]  w_idx;
    logic        w_match;
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_cand_nxt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_inc;
    logic        w_accept;

    assign w_sample = (r_dwell_cnt == c_dwell_last);

    // Rows are sampled only on the last dwell cycle, long after the
    // synchroniser has settled on the currently driven column.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_row_meta  <= 4'hF;
            r_row_sync  <= 4'hF;
            r_dwell_cnt <= '0;
            r_col_idx   <= 2'd0;
            r_snapshot  <= 16'd0;
            r_scan_end  <= 1'b0;
        end else begin
            r_row_meta  <= kp.row_n;
            r_row_sync  <= r_row_meta;
            r_dwell_cnt <= r_dwell_cnt + SCAN_DIV_BITS'(1);
            r_scan_end  <= w_sample && (r_col_idx == 2'd3);
            if (r_scan_end) begin
                r_snapshot <= 16'd0;
            end
            if (w_sample) begin
                r_col_idx <= r_col_idx + 2'd1;
                for (int r = 0; r < 4; r++) begin
                    r_snapshot[{2'(r), r_col_idx}] <= ~r_row_sync[r];
                end
            end
        end
    end

    assign kp.col_n = ~(4'b0001 << r_col_idx);

    always_comb begin
        w_any = |r_snapshot;
        w_multi = |(r_snapshot & (r_snapshot - 16'd1));
        w_single = w_any && !w_multi;
        w_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (r_snapshot[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_match   = w_single && (w_idx == r_cand);
    assign w_cnt_inc = r_cnt + 4'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        if (r_scan_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_single) begin
                        w_cand_nxt = w_idx;
                        w_cnt_nxt  = 4'd1;
                        if (c_deb <= 4'd1) begin
                            w_state_nxt = S_PRESSED;
                            w_accept    = 1'b1;
                        end else begin
                            w_state_nxt = S_PRS_DEB;
                        end
                    end
                end
                S_PRS_DEB: begin
                    if (w_match) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= c_deb) begin
                            w_state_nxt = S_PRESSED;
                            w_accept    = 1'b1;
                        end
                    end else if (w_single) begin
                        w_cand_nxt = w_idx;
                        w_cnt_nxt  = 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_PRESSED: begin
                    if (!w_match) begin
                        w_cnt_nxt   = 4'd1;
                        w_state_nxt = (c_deb <= 4'd1) ? S_IDLE : S_REL_DEB;
                    end
                end
                default: begin
                    // A different key while releasing counts as release; it
                    // gets no shortcut and must debounce again from idle.
                    if (w_match) begin
                        w_state_nxt = S_PRESSED;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc >= c_deb) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= S_IDLE;
            r_cand      <= 4'd0;
            r_cnt       <= 4'd0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
            r_multi_key <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_valid <= w_accept;
            r_key_held  <= (w_state_nxt == S_PRESSED) || (w_state_nxt == S_REL_DEB);
            if (w_accept) begin
                r_key_code <= key_map(w_cand_nxt);
            end
            if (r_scan_end) begin
                r_multi_key <= w_multi;
            end
        end
    end

    assign kp.key_code  = r_key_code;
    assign kp.key_valid = r_key_valid;
    assign kp.key_held  = r_key_held;
    assign kp.multi_key = r_multi_key;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
//------------------------------------------------------------------------------
// Module : tb_keypad_scanner
// Brief  : Self-checking bench for keypad_scanner with a scan-level key model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_keypad_scanner;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] keys = 16'd0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          obs_pulses = 0;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SCAN_DIV_BITS  (2),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk (clk),
        .clr (clr),
        .kp  (kp)
    );

    always #5 clk = ~clk;

    // Key (r,c) down shorts row r to column c; the row reads low only while c is driven.
    assign kp.row_n = {~|(keys[15:12] & ~kp.col_n), ~|(keys[11:8] & ~kp.col_n),
                       ~|(keys[7:4]   & ~kp.col_n), ~|(keys[3:0]  & ~kp.col_n)};

    always @(negedge clk) if (kp.key_valid === 1'b1) pulses++;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

    // Scan-level reference: what the keypad looked like across each whole scan.
    bit         m_held, m_valid, m_multi;
    int         m_run, m_run_key, m_rel, m_held_key;
    logic [3:0] m_code;

    task automatic model_reset();
        m_held = 0; m_valid = 0; m_multi = 0;
        m_run = 0; m_run_key = -1; m_rel = 0; m_held_key = -1;
        m_code = 4'h0;
    endtask

    task automatic model_step(input logic [15:0] s);
        int n, k;
        n = $countones(s);
        k = -1;
        for (int i = 0; i < 16; i++) if (s[i] && n == 1) k = i;
        m_multi = (n > 1);
        m_valid = 0;
        if (!m_held) begin
            if (k >= 0) begin
                if (m_run > 0 && k == m_run_key) m_run++;
                else begin m_run_key = k; m_run = 1; end
                if (m_run >= DEB) begin
                    m_held = 1; m_held_key = k; m_code = keymap[k]; m_valid = 1; m_rel = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (k == m_held_key) begin
            m_rel = 0;
        end else begin
            m_rel++;
            if (m_rel >= DEB) begin m_held = 0; m_run = 0; end
        end
    endtask

    // Entered and left at cycle 1 of a scan, just after the falling edge; the
    // outputs then reflect the scan that was just driven.
    task automatic scan(input logic [15:0] s);
        int p0;
        keys = s;
        p0 = pulses;
        repeat (16) @(posedge clk);
        @(negedge clk);
        #1;
        obs_pulses = pulses - p0;
        model_step(s);
    endtask

    task automatic release_reset(input logic [15:0] s);
        keys = s;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        model_reset();
    endtask

    function automatic logic [8:0] observed();
        return {kp.key_valid, 2'(obs_pulses > 3 ? 3 : obs_pulses), kp.key_code,
                kp.key_held, kp.multi_key};
    endfunction

    function automatic logic [8:0] expected();
        return {m_valid, 2'(m_valid ? 1 : 0), m_code, m_held, m_multi};
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        release_reset(16'd0);
        repeat (6) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        checks++;
        if ({kp.col_n, kp.key_code, kp.key_valid, kp.key_held, kp.multi_key} !== 11'b1110_0000_000) begin
            errors++;
            $display("FAIL reset: col/code/valid/held/multi got %b required %b",
                     {kp.col_n, kp.key_code, kp.key_valid, kp.key_held, kp.multi_key}, 11'b1110_0000_000);
        end
        repeat (2) @(posedge clk);
        release_reset(16'd0);
    endtask

    task automatic test_col_sequence();
        logic [3:0] one;
        logic [3:0] exp;
        one = 4'b0001;
        for (int i = 1; i <= 32; i++) begin
            exp = ~(one << ((i % 16) / 4));
            checks++;
            if (kp.col_n !== exp) begin
                errors++;
                $display("FAIL col_seq cycle %0d: col_n got %b required %b", i, kp.col_n, exp);
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic run_table(input string name, input logic [15:0] seq[$]);
        for (int i = 0; i < seq.size(); i++) begin
            scan(seq[i]);
            checks++;
            if (observed() !== expected()) begin
                errors++;
                $display("FAIL %s scan %0d: valid/pulses/code/held/multi got %b required %b",
                         name, i, observed(), expected());
            end
        end
    endtask

    task automatic test_single_press();
        int p0;
        p0 = pulses;
        run_table("single_press", '{16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040, 16'h0040,
                                    16'h0000, 16'h0000, 16'h0000, 16'h0000});
        checks++;
        if (kp.key_code !== 4'h6 || pulses - p0 != 1 || kp.key_held !== 1'b0) begin
            errors++;
            $display("FAIL single_press summary: code %h pulses %0d held %b required 6 1 0",
                     kp.key_code, pulses - p0, kp.key_held);
        end
    endtask

    task automatic test_bounce();
        run_table("bounce", '{16'h2000, 16'h0000, 16'h2000, 16'h0000, 16'h2000, 16'h2000,
                              16'h2000, 16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        checks++;
        if (kp.key_code !== 4'hF) begin
            errors++;
            $display("FAIL bounce code: got %h required F", kp.key_code);
        end
    endtask

    task automatic test_repress();
        int p0;
        p0 = pulses;
        run_table("repress", '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h0000,
                               16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        checks++;
        if (pulses - p0 != 1 || kp.key_code !== 4'h1) begin
            errors++;
            $display("FAIL repress pulses/code: got %0d %h required 1 1", pulses - p0, kp.key_code);
        end
    endtask

    task automatic test_multi();
        run_table("multi", '{16'h0108, 16'h0108, 16'h0108, 16'h0008, 16'h0008, 16'h0008,
                             16'h0008, 16'h0000, 16'h0000, 16'h0000, 16'h0000});
        checks++;
        if (kp.key_code !== 4'hA || kp.multi_key !== 1'b0) begin
            errors++;
            $display("FAIL multi final: code %h multi %b required A 0", kp.key_code, kp.multi_key);
        end
    endtask

    task automatic test_reset_mid_press();
        int p0;
        run_table("pre_reset", '{16'h0400, 16'h0400});
        repeat (5) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        checks++;
        if ({kp.col_n, kp.key_code, kp.key_valid, kp.key_held, kp.multi_key} !== 11'b1110_0000_000) begin
            errors++;
            $display("FAIL reset_mid: col/code/valid/held/multi got %b required %b",
                     {kp.col_n, kp.key_code, kp.key_valid, kp.key_held, kp.multi_key}, 11'b1110_0000_000);
        end
        repeat (2) @(posedge clk);
        p0 = pulses;
        release_reset(16'h0400);
        run_table("post_reset", '{16'h0400, 16'h0400, 16'h0400, 16'h0400,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000});
        checks++;
        if (pulses - p0 != 1 || kp.key_code !== 4'h9) begin
            errors++;
            $display("FAIL reset_mid redebounce: pulses %0d code %h required 1 9", pulses - p0, kp.key_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] seq[$];
        logic [15:0] cur;
        int          r;
        cur = 16'd0;
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 11);
            if (r < 6)       cur = cur;
            else if (r < 8)  cur = 16'd0;
            else if (r < 11) cur = 16'd1 << $urandom_range(0, 15);
            else             cur = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
            seq.push_back(cur);
        end
        run_table("random", seq);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_col_sequence();
        test_single_press();
        test_bounce();
        test_repress();
        test_multi();
        test_reset_mid_press();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
